// File: rtl/sub1024_serial_if.sv
// Word-serial subtractor bus: operand stream in, difference stream and status out.
// The master drives the operands; the slave (the subtractor) drives results.
interface sub1024_serial_if #(
  parameter int W = 32
);
  logic         iStart;
  logic         iValid;
  logic [W-1:0] iX;
  logic [W-1:0] iY;
  logic [W-1:0] oZ;
  logic         oValid;
  logic         oBusy;
  logic         oFinish;
  logic         oBorrow;
  logic         oZero;

  modport master (
    output iStart, iValid, iX, iY,
    input  oZ, oValid, oBusy, oFinish, oBorrow, oZero
  );

  modport slave (
    input  iStart, iValid, iX, iY,
    output oZ, oValid, oBusy, oFinish, oBorrow, oZero
  );
endinterface

// File: rtl/sub1024_serial.sv
// Word-serial multi-precision subtractor Z = X - Y, LSW first.
// Borrow ripples between words; final borrow gives X<Y, zero-accumulator gives X==Y.
module sub1024_serial #(
  parameter int W  = 32,
  parameter int N  = 32,
  parameter int CW = 5
) (
  input  logic iClk,
  input  logic iRst_n,
  sub1024_serial_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic            r_borrow;
  logic            r_zacc;
  logic [W-1:0]    r_z;
  logic            r_valid;
  logic            r_finish;
  logic            r_oborrow;
  logic            r_ozero;

  logic            w_start;
  logic            w_acc;
  logic            w_last;
  logic [W:0]      w_diff;
  logic            w_dzero;

  assign w_start = (r_state == S_IDLE) && bus.iStart;
  assign w_acc   = (r_state == S_RUN) && bus.iValid;
  assign w_last  = w_acc && (r_cnt == CW'(N - 1));
  assign w_diff  = {1'b0, bus.iX} - {1'b0, bus.iY}
                 - {{W{1'b0}}, r_borrow};
  assign w_dzero = (w_diff[W-1:0] == '0);

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.iStart) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_cnt     <= '0;
      r_borrow  <= 1'b0;
      r_zacc    <= 1'b0;
      r_z       <= '0;
      r_valid   <= 1'b0;
      r_finish  <= 1'b0;
      r_oborrow <= 1'b0;
      r_ozero   <= 1'b0;
    end else begin
      r_valid  <= w_acc;
      r_finish <= w_last;
      if (w_start) begin
        r_cnt     <= '0;
        r_borrow  <= 1'b0;
        r_zacc    <= 1'b1;
        r_oborrow <= 1'b0;
        r_ozero   <= 1'b0;
      end
      if (w_acc) begin
        r_z      <= w_diff[W-1:0];
        r_borrow <= w_diff[W];
        r_zacc   <= r_zacc & w_dzero;
        r_cnt    <= r_cnt + CW'(1);
      end
      // Status lands together with the last word so it is valid during DONE
      if (w_last) begin
        r_oborrow <= w_diff[W];
        r_ozero   <= r_zacc & w_dzero;
      end
    end
  end

  assign bus.oZ      = r_z;
  assign bus.oValid  = r_valid;
  assign bus.oBusy   = (r_state != S_IDLE);
  assign bus.oFinish = r_finish;
  assign bus.oBorrow = r_oborrow;
  assign bus.oZero   = r_ozero;

endmodule

// File: tb/tb_sub1024_serial.sv
// Bench for sub1024_serial: directed operands drive a scoreboard queue,
// an independent monitor pops and compares every oValid word.
module tb_sub1024_serial;

  localparam int W  = 32;
  localparam int N  = 32;
  localparam int CW = 5;
  localparam int NW = W * N;

  typedef struct {
    logic [W-1:0] z;
    bit           last;
    bit           b;
    bit           zr;
  } item_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  item_t sb[$];

  sub1024_serial_if #(.W(W)) u_if ();

  sub1024_serial #(.W(W), .N(N), .CW(CW)) u_dut (
    .iClk   (clk),
    .iRst_n (rst_n),
    .bus    (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (u_if.oValid) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_word got %h want none", u_if.oZ);
        end else begin
          item_t e;
          e = sb.pop_front();
          chk("word", u_if.oZ, e.z);
          chk("finish_flag", {31'd0, u_if.oFinish}, {31'd0, e.last});
          if (e.last) begin
            chk("borrow", {31'd0, u_if.oBorrow}, {31'd0, e.b});
            chk("zero", {31'd0, u_if.oZero}, {31'd0, e.zr});
          end
        end
      end else if (u_if.oFinish) begin
        n_vec++;
        n_err++;
        $display("FAIL finish_without_valid got 1 want 0");
      end
    end
  end

  function automatic logic [NW-1:0] rnd();
    logic [NW-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = $urandom;
    return r;
  endfunction

  task automatic do_op(input logic [NW-1:0] x, input logic [NW-1:0] y,
                       input logic [NW-1:0] ez, input bit eb,
                       input bit ezr, input bit gaps, input bit poke,
                       input int stop);
    item_t it;
    int    waitc;
    for (int i = 0; i < stop; i++) begin
      it.z    = ez[i*W +: W];
      it.last = (i == N - 1);
      it.b    = eb;
      it.zr   = ezr;
      sb.push_back(it);
    end
    u_if.iStart = 1'b1;
    @(posedge clk); #1;
    u_if.iStart = 1'b0;
    chk("busy_after_start", {31'd0, u_if.oBusy}, 32'd1);
    for (int i = 0; i < stop; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          u_if.iValid = 1'b0;
          u_if.iX     = $urandom;
          u_if.iY     = $urandom;
          if (poke) u_if.iStart = 1'b1;
          @(posedge clk); #1;
          u_if.iStart = 1'b0;
          chk("busy_stall", {31'd0, u_if.oBusy}, 32'd1);
        end
      end
      u_if.iValid = 1'b1;
      u_if.iX     = x[i*W +: W];
      u_if.iY     = y[i*W +: W];
      if (poke && (i == 3)) u_if.iStart = 1'b1;
      @(posedge clk); #1;
      u_if.iStart = 1'b0;
      u_if.iValid = 1'b0;
    end
    if (stop == N) begin
      chk("finish_timing", {31'd0, u_if.oFinish}, 32'd1);
      waitc = 0;
      while (u_if.oBusy && waitc < 8) begin
        @(posedge clk); #1;
        waitc++;
      end
      chk("busy_drop", {31'd0, u_if.oBusy}, 32'd0);
    end
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_oZ"}, u_if.oZ, '0);
    chk({tag, "_oValid"}, {31'd0, u_if.oValid}, 32'd0);
    chk({tag, "_oBusy"}, {31'd0, u_if.oBusy}, 32'd0);
    chk({tag, "_oFinish"}, {31'd0, u_if.oFinish}, 32'd0);
    chk({tag, "_oBorrow"}, {31'd0, u_if.oBorrow}, 32'd0);
    chk({tag, "_oZero"}, {31'd0, u_if.oZero}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end

  initial begin
    logic [NW-1:0] x, y, ez, t1x, t1y, t1z;
    logic [NW:0]   full;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    u_if.iStart = 1'b0;
    u_if.iValid = 1'b0;
    u_if.iX     = '0;
    u_if.iY     = '0;
    #12;
    chk_zero_outs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: 5 - 3
    t1x = NW'(5);
    t1y = NW'(3);
    t1z = NW'(2);
    do_op(t1x, t1y, t1z, 1'b0, 1'b0, 1'b0, 1'b0, N);

    // 2: 0 - 1, full borrow ripple
    x  = '0;
    y  = NW'(1);
    ez = '1;
    do_op(x, y, ez, 1'b1, 1'b0, 1'b0, 1'b0, N);

    // 3: X == Y, back to back
    for (int k = 0; k < 3; k++) begin
      x = rnd();
      do_op(x, x, '0, 1'b0, 1'b1, 1'b0, 1'b0, N);
    end

    // 4: borrow across word 0 into word 1
    x  = NW'(64'h1_0000_0000);
    y  = NW'(1);
    ez = NW'(32'hFFFF_FFFF);
    do_op(x, y, ez, 1'b0, 1'b0, 1'b0, 1'b0, N);

    // 5: random operands with stalls against a full-width model
    for (int k = 0; k < 4; k++) begin
      x = rnd();
      y = rnd();
      if (k == 1) y[NW-1] = ~x[NW-1];
      full = {1'b0, x} - {1'b0, y};
      do_op(x, y, full[NW-1:0], full[NW], full[NW-1:0] == '0,
            1'b1, 1'b0, N);
    end

    // 6a: ignored iStart pulses in RUN
    x = rnd();
    y = rnd();
    full = {1'b0, x} - {1'b0, y};
    do_op(x, y, full[NW-1:0], full[NW], 1'b0, 1'b1, 1'b1, N);

    // 6b: abort after word 10 with reset
    x = rnd();
    y = rnd();
    full = {1'b0, x} - {1'b0, y};
    do_op(x, y, full[NW-1:0], full[NW], 1'b0, 1'b0, 1'b1, 10);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_zero_outs("abort");
    chk("abort_sb_drained", sb.size(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_op(t1x, t1y, t1z, 1'b0, 1'b0, 1'b0, 1'b0, N);

    repeat (4) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
